// File: rtl/rv32i_udp_reply_tx.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_udp_reply_tx
// Description : Streams one Ethernet/IPv4/UDP reply frame (cmd + result) on
//               the MII TX nibble bus, with preamble, IP checksum and FCS.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_udp_reply_tx #(
    parameter logic [47:0] SRC_MAC  = 48'h000A35010203,
    parameter logic [47:0] DST_MAC  = 48'hFFFFFFFFFFFF,
    parameter logic [31:0] SRC_IP   = 32'hC0A80002,
    parameter logic [31:0] DST_IP   = 32'hC0A80003,
    parameter logic [15:0] SRC_PORT = 16'd8080,
    parameter logic [15:0] DST_PORT = 16'd8080,
    parameter logic [7:0]  TTL      = 8'h80
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        send,
    input  logic [31:0] cmd,
    input  logic [31:0] result,
    output logic        busy,
    output logic        done,
    output logic        txen,
    output logic        txer,
    output logic [3:0]  tdata
);

    localparam logic [2:0]  c_S_IDLE   = 3'd0;
    localparam logic [2:0]  c_S_PRE    = 3'd1;
    localparam logic [2:0]  c_S_BODY   = 3'd2;
    localparam logic [2:0]  c_S_FCS    = 3'd3;
    localparam logic [2:0]  c_S_IFG    = 3'd4;
    localparam logic [7:0]  c_POS_BODY = 8'd16;
    localparam logic [7:0]  c_POS_FCS  = 8'd136;
    localparam logic [7:0]  c_POS_END  = 8'd144;
    localparam logic [4:0]  c_IFG_LAST = 5'd23;
    localparam logic [31:0] c_CRC_POLY = 32'hEDB88320;

    logic [2:0]   r_state;
    logic [7:0]   r_pos;
    logic [4:0]   r_ifg;
    logic [15:0]  r_ident;
    logic [31:0]  r_cmd;
    logic [31:0]  r_result;
    logic [31:0]  r_crc;
    logic         r_busy;
    logic         r_done;
    logic         r_txen;
    logic [3:0]   r_tdata;

    logic [19:0]  w_sum;
    logic [16:0]  w_fold1;
    logic [15:0]  w_fold2;
    logic [15:0]  w_csum;
    logic [479:0] w_body;
    logic [7:0]   w_boff;
    logic [5:0]   w_bidx;
    logic [7:0]   w_byte;
    logic [3:0]   w_nib;

    // Reflected CRC-32 advanced by one nibble (LSB first)
    function automatic logic [31:0] crc_nibble(input logic [31:0] crc, input logic [3:0] nib);
        logic [31:0] c;
        c = crc ^ {28'h0, nib};
        for (int i = 0; i < 4; i++) begin
            c = c[0] ? ((c >> 1) ^ c_CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    assign w_sum = 20'h04500 + 20'h00024 + {4'h0, r_ident} + 20'h04000
                 + {4'h0, TTL, 8'h11}
                 + {4'h0, SRC_IP[31:16]} + {4'h0, SRC_IP[15:0]}
                 + {4'h0, DST_IP[31:16]} + {4'h0, DST_IP[15:0]};
    // Two folds suffice: the first can carry at most one bit into bit 16
    assign w_fold1 = {1'b0, w_sum[15:0]} + {13'h0, w_sum[19:16]};
    assign w_fold2 = w_fold1[15:0] + {15'h0, w_fold1[16]};
    assign w_csum  = ~w_fold2;

    assign w_body = {DST_MAC, SRC_MAC, 16'h0800,
                     8'h45, 8'h00, 16'h0024, r_ident, 16'h4000, TTL, 8'h11, w_csum,
                     SRC_IP, DST_IP,
                     SRC_PORT, DST_PORT, 16'h0010, 16'h0000,
                     r_cmd, r_result, 80'h0};

    assign w_boff = r_pos - c_POS_BODY;
    assign w_bidx = (w_boff > 8'd119) ? 6'd0 : w_boff[6:1];
    assign w_byte = w_body[9'd479 - {w_bidx, 3'b000} -: 8];
    assign w_nib  = r_pos[0] ? w_byte[7:4] : w_byte[3:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_S_IDLE;
            r_pos    <= 8'd0;
            r_ifg    <= 5'd0;
            r_ident  <= 16'd0;
            r_cmd    <= 32'd0;
            r_result <= 32'd0;
            r_crc    <= 32'hFFFFFFFF;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_txen   <= 1'b0;
            r_tdata  <= 4'h0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (send) begin
                        r_cmd    <= cmd;
                        r_result <= result;
                        r_crc    <= 32'hFFFFFFFF;
                        r_pos    <= 8'd1;
                        r_tdata  <= 4'h5;
                        r_txen   <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= c_S_PRE;
                    end
                end
                c_S_PRE, c_S_BODY, c_S_FCS: begin
                    // r_pos is the index of the nibble presented at this edge
                    if (r_pos == c_POS_END) begin
                        r_txen  <= 1'b0;
                        r_tdata <= 4'h0;
                        r_done  <= 1'b1;
                        r_ident <= r_ident + 16'd1;
                        r_ifg   <= 5'd0;
                        r_state <= c_S_IFG;
                    end else begin
                        r_pos <= r_pos + 8'd1;
                        if (r_pos < c_POS_BODY) begin
                            r_tdata <= (r_pos == c_POS_BODY - 8'd1) ? 4'hD : 4'h5;
                        end else if (r_pos < c_POS_FCS) begin
                            r_tdata <= w_nib;
                            r_crc   <= crc_nibble(r_crc, w_nib);
                            r_state <= c_S_BODY;
                        end else begin
                            r_tdata <= ~r_crc[3:0];
                            r_crc   <= {4'h0, r_crc[31:4]};
                            r_state <= c_S_FCS;
                        end
                    end
                end
                c_S_IFG: begin
                    if (r_ifg == c_IFG_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= c_S_IDLE;
                    end else begin
                        r_ifg <= r_ifg + 5'd1;
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign txen  = r_txen;
    assign txer  = 1'b0;
    assign tdata = r_tdata;

endmodule
`default_nettype wire
